// File: rtl/tpm_pkg.sv
// Shared types for the triple-ported memory and its request queues.
// Provides the address/data widths and the packed request word
// {addr, data, wen} that matches the memory's internal request packing.
package tpm_pkg;

  localparam int unsigned TPM_ADDR_W = 12;
  localparam int unsigned TPM_DATA_W = 16;
  localparam int unsigned TPM_REQ_W  = TPM_ADDR_W + TPM_DATA_W + 1;

  typedef struct packed {
    logic [TPM_ADDR_W-1:0] addr;
    logic [TPM_DATA_W-1:0] data;
    logic                  wen;
  } tpm_req_t;

endpackage

// File: rtl/req_fifo_storage.sv
// Register array backing the port request queue.
// Ports:
//   clk      - clock, rising edge
//   wr_en    - write wr_data into slot wr_ptr this cycle
//   wr_ptr   - write slot index
//   wr_data  - request word to store
//   rd_ptr   - read slot index
//   rd_data  - request word at rd_ptr (combinational read)
// Pointer, occupancy and handshake control live in the parent.
module req_fifo_storage
  import tpm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  tpm_req_t                 wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output tpm_req_t                 rd_data
);

  tpm_req_t slots [DEPTH];

  // Data slots carry no reset; the parent masks them whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      slots[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = slots[rd_ptr];

endmodule

// File: rtl/port_request_queue.sv
// Per-port request buffer in front of one port of the triple-ported memory.
// Accepts requests over valid/ready, stores them in a DEPTH-entry FIFO and
// presents the head on the memory port, holding it while freeze_inputs=1.
// Ports:
//   clk, reset                          - clock, synchronous active-high reset
//   req_addr/req_data/req_wen/req_valid - upstream request
//   req_ready                           - queue can accept this cycle
//   freeze_inputs                       - memory ignores its port inputs this cycle
//   mem_addr/mem_data_in/mem_wen        - head request toward the memory
//   mem_valid                           - head request valid
//   count                               - current occupancy
// Optional build macro PORT_REQ_QUEUE_FALLTHROUGH_EN: when empty and not frozen,
// a valid request is routed straight to mem_* in the same cycle without being stored.
module port_request_queue
  import tpm_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = TPM_ADDR_W,
  parameter int unsigned DATA_W = TPM_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_data,
  input  logic                       req_wen,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       freeze_inputs,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data_in,
  output logic                       mem_wen,
  output logic                       mem_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             bypass;
  logic             push;
  logic             pop;
  tpm_req_t         wr_data;
  tpm_req_t         head;

  assign empty = (count_q == '0);

`ifdef PORT_REQ_QUEUE_FALLTHROUGH_EN
  // Empty queue and a capturing memory: hand the request straight through.
  assign bypass = empty & req_valid & ~freeze_inputs & ~reset;
`else
  assign bypass = 1'b0;
`endif

  // Ready depends only on occupancy and reset, never on freeze_inputs.
  assign req_ready = (count_q != CNT_W'(DEPTH)) & ~reset;
  assign push      = req_valid & req_ready & ~bypass;
  assign pop       = ~empty & ~freeze_inputs;

  assign wr_data.addr = TPM_ADDR_W'(req_addr);
  assign wr_data.data = TPM_DATA_W'(req_data);
  assign wr_data.wen  = req_wen;

  req_fifo_storage #(.DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .wr_en   (push),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_data),
    .rd_ptr  (rd_ptr),
    .rd_data (head)
  );

  // Pointers and occupancy; pointers wrap by explicit compare so DEPTH need not be a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Memory-side request: bypassed request, else head entry, else zeros.
  always_comb begin
    mem_valid   = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    mem_wen     = 1'b0;
    if (bypass) begin
      mem_valid   = 1'b1;
      mem_addr    = req_addr;
      mem_data_in = req_data;
      mem_wen     = req_wen;
    end else if (!empty) begin
      mem_valid   = 1'b1;
      mem_addr    = ADDR_W'(head.addr);
      mem_data_in = DATA_W'(head.data);
      mem_wen     = head.wen;
    end
  end

  assign count = count_q;

endmodule
